// File: rtl/sync_recover_pkg.sv
// Shared definitions for the sync recovery block: state encoding, coordinate
// width and the default 640x480 timing constants shared with the generator.
package sync_recover_pkg;

  localparam int CW = 12;

  typedef logic [CW-1:0] coord_t;

  localparam coord_t CMAX = 12'hFFF;

  // Receiver state encoding
  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] HSTABLE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  // Default 640x480 timing as produced by the generator
  localparam int DEF_XRES       = 640;
  localparam int DEF_YRES       = 480;
  localparam int DEF_HS_OFFSET  = 658;
  localparam int DEF_VS_OFFSET  = 490;
  localparam int DEF_LOCK_LINES = 4;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic coord_t sat_inc(input coord_t v);
    return (v == CMAX) ? CMAX : v + 12'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop input pipe on an active-high sync line with rising-edge detect.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic rise_o
);

  logic s_q;
  logic s_q2;

  // Register the sync input twice; the edge is seen between the two stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q  <= 1'b0;
      s_q2 <= 1'b0;
    end else begin
      s_q  <= sync_i;
      s_q2 <= s_q;
    end
  end

  assign rise_o = s_q & ~s_q2;

endmodule

// File: rtl/sync_recover.sv
// Receive side of the VGA timing interface: rebuilds x/y/border from hs/vs,
// measures line and frame periods, and tracks lock with a loss counter.
module sync_recover
  import sync_recover_pkg::*;
#(
  parameter int XRES       = DEF_XRES,
  parameter int YRES       = DEF_YRES,
  parameter int HS_OFFSET  = DEF_HS_OFFSET,
  parameter int VS_OFFSET  = DEF_VS_OFFSET,
  parameter int LOCK_LINES = DEF_LOCK_LINES
) (
  input  logic          pixclk,
  input  logic          rst,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          border,
  output logic          locked,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] frame_lines,
  output logic [7:0]    lost_cnt
);

  localparam coord_t     XRES_C = coord_t'(XRES);
  localparam coord_t     YRES_C = coord_t'(YRES);
  localparam coord_t     HS_C   = coord_t'(HS_OFFSET);
  localparam coord_t     VS_C   = coord_t'(VS_OFFSET);
  localparam logic [7:0] LOCK_C = 8'(LOCK_LINES);

  logic hs_rise;
  logic vs_rise;

  coord_t     hcnt_q, hcnt_d;
  coord_t     vcnt_q, vcnt_d;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  coord_t     line_len_q, line_len_d;
  coord_t     frame_lines_q, frame_lines_d;
  logic       border_q, border_d;
  logic       locked_q, locked_d;
  logic [1:0] state_q, state_d;
  logic [7:0] match_q, match_d;
  logic [7:0] lost_q, lost_d;
  logic       x_wrap;
  logic       h_bad;
  logic       v_bad;

  sync_edge u_hs_edge (
    .clk_i  (pixclk),
    .rst_i  (rst),
    .sync_i (hs_in),
    .rise_o (hs_rise)
  );

  sync_edge u_vs_edge (
    .clk_i  (pixclk),
    .rst_i  (rst),
    .sync_i (vs_in),
    .rise_o (vs_rise)
  );

  // Next-state for counters, coordinates, measurements and the lock FSM
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    x_d           = x_q;
    y_d           = y_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    state_d       = state_q;
    match_d       = match_q;
    lost_d        = lost_q;
    x_wrap        = 1'b0;

    // Line period: cycles since the previous detected hs edge
    if (hs_rise) begin
      hcnt_d     = 12'd1;
      line_len_d = hcnt_q;
    end else begin
      hcnt_d = sat_inc(hcnt_q);
    end

    // Frame period: hs edges since the previous vs edge; a coincident hs is not counted
    if (vs_rise) begin
      vcnt_d        = 12'd0;
      frame_lines_d = vcnt_q;
    end else if (hs_rise) begin
      vcnt_d = sat_inc(vcnt_q);
    end else begin
      vcnt_d = vcnt_q;
    end

    // Column: re-anchored on every hs edge, wraps at the measured line length
    if (hs_rise) begin
      x_d = HS_C;
    end else if ((line_len_q != 12'd0) && (x_q == line_len_q - 12'd1)) begin
      x_d    = 12'd0;
      x_wrap = 1'b1;
    end else begin
      x_d = sat_inc(x_q);
    end

    // Row: re-anchored on vs edge, otherwise advances when the column wraps
    if (vs_rise) begin
      y_d = VS_C;
    end else if (x_wrap) begin
      y_d = (y_q == frame_lines_q - 12'd1) ? 12'd0 : sat_inc(y_q);
    end else begin
      y_d = y_q;
    end

    h_bad = hs_rise & (hcnt_q != line_len_q);
    v_bad = vs_rise & (vcnt_q != frame_lines_q);

    case (state_q)
      HUNT: begin
        if (match_q == LOCK_C) begin
          state_d = HSTABLE;
        end else if (hs_rise) begin
          match_d = h_bad ? 8'd0 : match_q + 8'd1;
        end else begin
          match_d = match_q;
        end
      end
      HSTABLE: begin
        if (h_bad) begin
          state_d = HUNT;
          match_d = 8'd0;
        end else if (vs_rise && !v_bad && (vcnt_q != 12'd0)) begin
          state_d = LOCKED;
        end else begin
          state_d = HSTABLE;
        end
      end
      LOCKED: begin
        if (h_bad || v_bad || (hcnt_q == CMAX)) begin
          state_d = HUNT;
          match_d = 8'd0;
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = HUNT;
        match_d = 8'd0;
      end
    endcase

    locked_d = (state_d == LOCKED);
    border_d = ~locked_d | (x_d >= XRES_C) | (y_d >= YRES_C);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge pixclk) begin
    if (rst) begin
      hcnt_q        <= 12'd0;
      vcnt_q        <= 12'd0;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      line_len_q    <= 12'd0;
      frame_lines_q <= 12'd0;
      border_q      <= 1'b0;
      locked_q      <= 1'b0;
      state_q       <= HUNT;
      match_q       <= 8'd0;
      lost_q        <= 8'd0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      border_q      <= border_d;
      locked_q      <= locked_d;
      state_q       <= state_d;
      match_q       <= match_d;
      lost_q        <= lost_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign border      = border_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign lost_cnt    = lost_q;

endmodule

// File: tb/tb_sync_recover.sv
// Directed bench for sync_recover driven by a small in-bench sync generator
// (reduced raster so several frames fit in a short run).
module tb_sync_recover;

  localparam int H_TOTAL  = 41;
  localparam int V_TOTAL  = 26;
  localparam int XR       = 24;
  localparam int YR       = 20;
  localparam int HS_START = 30;
  localparam int HS_W     = 4;
  localparam int VS_START = 22;
  localparam int VS_W     = 2;
  localparam int HS_OFF   = HS_START + 2;
  localparam int VS_OFF   = VS_START;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        pixclk = 1'b0;
  logic        rst    = 1'b1;
  logic        hs_in  = 1'b0;
  logic        vs_in  = 1'b0;
  logic [11:0] x;
  logic [11:0] y;
  logic        border;
  logic        locked;
  logic [11:0] line_len;
  logic [11:0] frame_lines;
  logic [7:0]  lost_cnt;

  sync_recover #(
    .XRES       (XR),
    .YRES       (YR),
    .HS_OFFSET  (HS_OFF),
    .VS_OFFSET  (VS_OFF),
    .LOCK_LINES (4)
  ) dut (
    .pixclk      (pixclk),
    .rst         (rst),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .x           (x),
    .y           (y),
    .border      (border),
    .locked      (locked),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .lost_cnt    (lost_cnt)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gx, gy, hlen;
  bit   mask = 1'b0;
  bit   short_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance the reference generator by one pixel and drive hs/vs from it
  task automatic gen_step();
    gx++;
    if (gx >= hlen) begin
      gx        = 0;
      gy        = (gy == V_TOTAL - 1) ? 0 : gy + 1;
      hlen      = short_req ? H_TOTAL - 1 : H_TOTAL;
      short_req = 1'b0;
    end
    hs_in = !mask && (gx >= HS_START) && (gx < HS_START + HS_W);
    vs_in = !mask && (gy >= VS_START) && (gy < VS_START + VS_W);
  endtask

  task automatic run_cmp(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge pixclk);
      gen_step();
      sb.push_back('{x: 12'(gx), y: 12'(gy), b: ((gx >= XR) || (gy >= YR))});
      #1;
      e = sb.pop_front();
      chk("x", 32'(x), 32'(e.x));
      chk("y", 32'(y), 32'(e.y));
      chk("border", 32'(border), 32'(e.b));
    end
  endtask

  task automatic wait_locked(input string tag, input logic want, input int budget);
    int n = 0;
    while (locked !== want && n < budget) begin
      @(negedge pixclk);
      gen_step();
      #1;
      n++;
    end
    chk(tag, 32'(locked), 32'(want));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, 32'(x), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'd0);
    chk({tag, "_border"}, 32'(border), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_line_len"}, 32'(line_len), 32'd0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
    chk({tag, "_lost"}, 32'(lost_cnt), 32'd0);
  endtask

  task automatic drive(input logic h, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pixclk);
      hs_in = h;
      vs_in = v;
    end
  endtask

  // Hard stop if the sequence ever stalls
  initial begin
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    gx   = H_TOTAL - 1;
    gy   = V_TOTAL - 1;
    hlen = H_TOTAL;
    repeat (3) @(negedge pixclk);
    #1;
    chk_zero("reset");

    // First lock from a clean start
    @(negedge pixclk);
    rst = 1'b0;
    gen_step();
    wait_locked("first_lock", 1'b1, 4 * FRAME);
    chk("line_len", 32'(line_len), 32'(H_TOTAL));
    chk("frame_lines", 32'(frame_lines), 32'(V_TOTAL));
    chk("lost_initial", 32'(lost_cnt), 32'd0);
    run_cmp(2 * FRAME);

    // Hold hs (and vs) low while locked: timeout on the line counter
    mask  = 1'b1;
    hs_in = 1'b0;
    vs_in = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge pixclk);
      gen_step();
    end
    #1;
    chk("locked_before_timeout", 32'(locked), 32'd1);
    wait_locked("timeout_unlock", 1'b0, 300);
    chk("lost_after_timeout", 32'(lost_cnt), 32'd1);
    mask = 1'b0;
    wait_locked("relock_timeout", 1'b1, 4 * FRAME);
    run_cmp(FRAME);

    // One short line while locked
    short_req = 1'b1;
    wait_locked("short_unlock", 1'b0, 4 * H_TOTAL);
    chk("lost_after_short", 32'(lost_cnt), 32'd2);
    wait_locked("relock_short", 1'b1, 2 * FRAME);
    chk("line_len_relock", 32'(line_len), 32'(H_TOTAL));
    run_cmp(FRAME);

    // One-cycle reset in the middle of a frame
    run_cmp(FRAME / 3);
    @(negedge pixclk);
    gen_step();
    rst = 1'b1;
    @(negedge pixclk);
    gen_step();
    rst = 1'b0;
    #1;
    chk_zero("midframe_reset");
    wait_locked("relock_reset", 1'b1, 4 * FRAME);
    chk("lost_after_reset", 32'(lost_cnt), 32'd0);
    run_cmp(FRAME);

    // Coincident hs/vs edge: that hs is not counted, y re-anchors
    drive(1'b0, 1'b0, 1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1);
      drive(1'b0, 1'b0, 9);
    end
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b0, 2);
    #1;
    chk("coinc_x", 32'(x), 32'(HS_OFF));
    chk("coinc_y", 32'(y), 32'(VS_OFF));
    chk("coinc_frame_lines", 32'(frame_lines), 32'd3);
    chk("coinc_line_len", 32'(line_len), 32'd10);
    drive(1'b0, 1'b0, 8);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1);
      drive(1'b0, 1'b0, 9);
    end
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 2);
    #1;
    chk("after_coinc_frame_lines", 32'(frame_lines), 32'd2);
    chk("after_coinc_locked", 32'(locked), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
